// File: rtl/mem_line_responder_pkg.sv
// Shared constants for the cache <-> memory line interface: line geometry,
// responder FSM encodings and the captured-operation type.
package mem_line_responder_pkg;

    // Line geometry shared with the cache controller.
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LINE_WORDS  = 4;
    localparam int unsigned LINE_W      = WORD_W * LINE_WORDS;
    localparam int unsigned LINE_ADDR_W = 28;

    // Responder FSM encodings (kept as plain constants for legacy users).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Width of the latency down-counter; covers LATENCY up to 255.
    localparam int unsigned LAT_CNT_W = 8;

    // Operation captured at request acceptance.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/mem_line_array.sv
// Line storage for the memory responder: one synchronous write port and one
// registered read port with read enable. No reset, so contents survive a
// responder reset and simulation may preload it.
module mem_line_array
    import mem_line_responder_pkg::*;
#(
    parameter int unsigned DATA_W     = LINE_W,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: commit one line per enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: register the addressed line; hold it while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the 128-bit cache line interface. Accepts one
// line read or write at a time, answers after LATENCY cycles with a single
// mem_ready pulse, and keeps saturating read/write statistics.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = LINE_ADDR_W,
    parameter int unsigned DATA_W     = LINE_W,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    // Counter load value: one cycle of the latency is spent in the accept edge.
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    mem_op_e               op_q, op_in;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  cap_en;
    logic                  rd_en;
    logic                  req_held;
    logic                  rdata_vld_q;
    logic                  proto_err_q;
    logic [CNT_W-1:0]      rd_count_q, wr_count_q;
    logic                  arr_we;
    logic [DEPTH_LOG2-1:0] arr_raddr;
    logic [DATA_W-1:0]     arr_rdata;

    // Upper line-address bits alias onto the same storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    // A simultaneous read+write is served as a write.
    assign op_in = mem_write ? OP_WRITE : OP_READ;

    // The request line belonging to the accepted operation must stay high.
    assign req_held = (op_q == OP_WRITE) ? mem_write : mem_read;

    // Next-state logic: accept, count down, respond, or abort.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        cap_en    = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    cap_en = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        rd_en   = (op_in == OP_READ);
                    end else begin
                        state_d   = ST_BUSY;
                        lat_cnt_d = LAT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (!req_held) begin
                    // Initiator withdrew: drop the transaction silently.
                    state_d   = ST_IDLE;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                    if (lat_cnt_q == LAT_CNT_W'(1)) begin
                        state_d = ST_RESP;
                        rd_en   = (op_q == OP_READ);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                lat_cnt_d = '0;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Request capture; held for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cap_en) begin
            op_q    <= op_in;
            addr_q  <= mem_addr[DEPTH_LOG2-1:0];
            wdata_q <= mem_wdata;
        end
    end

    // Sticky protocol-error flag for overlapping read and write requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_q <= 1'b0;
        end else if (mem_read && mem_write) begin
            proto_err_q <= 1'b1;
        end
    end

    // Completion statistics, counted in the response cycle and saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == ST_RESP) begin
            if (op_q == OP_READ && !(&rd_count_q)) begin
                rd_count_q <= rd_count_q + CNT_W'(1);
            end
            if (op_q == OP_WRITE && !(&wr_count_q)) begin
                wr_count_q <= wr_count_q + CNT_W'(1);
            end
        end
    end

    // The array read register has no reset, so mask it until a read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_vld_q <= 1'b0;
        end else if (rd_en) begin
            rdata_vld_q <= 1'b1;
        end
    end

    // With LATENCY=1 the read is launched straight from the request inputs.
    assign arr_raddr = (state_q == ST_IDLE) ? mem_addr[DEPTH_LOG2-1:0] : addr_q;

    // Commit at the edge that ends RESP; an async reset in RESP cancels it.
    assign arr_we = (state_q == ST_RESP) && (op_q == OP_WRITE);

    mem_line_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .re    (rd_en),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    assign mem_rdata = rdata_vld_q ? arr_rdata : '0;
    assign mem_ready = (state_q == ST_RESP);
    assign proto_err = proto_err_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1, 2-bit-counter instance for the short-latency
// and counter-saturation cases.
module tb_mem_line_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         a_read, a_write, a_ready, a_perr;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic [15:0]  a_rdc, a_wrc;
    logic         b_read, b_write, b_ready, b_perr;
    logic [27:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic [1:0]   b_rdc, b_wrc;

    int n_cmp = 0;
    int n_bad = 0;

    mem_line_responder #(
        .ADDR_W (28), .DATA_W (128), .DEPTH_LOG2 (10), .LATENCY (4), .CNT_W (16)
    ) dut (
        .clk (clk), .rst_n (rst_n), .mem_read (a_read), .mem_write (a_write),
        .mem_addr (a_addr), .mem_wdata (a_wdata), .mem_rdata (a_rdata),
        .mem_ready (a_ready), .proto_err (a_perr), .rd_count (a_rdc), .wr_count (a_wrc)
    );

    mem_line_responder #(
        .ADDR_W (28), .DATA_W (128), .DEPTH_LOG2 (10), .LATENCY (1), .CNT_W (2)
    ) dut1 (
        .clk (clk), .rst_n (rst_n), .mem_read (b_read), .mem_write (b_write),
        .mem_addr (b_addr), .mem_wdata (b_wdata), .mem_rdata (b_rdata),
        .mem_ready (b_ready), .proto_err (b_perr), .rd_count (b_rdc), .wr_count (b_wrc)
    );

    localparam logic [127:0] L5   = 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF;
    localparam logic [127:0] L12  = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] L7   = 128'h70707070_71717171_72727272_73737373;
    localparam logic [127:0] L3   = 128'h30303030_31313131_32323232_33333333;
    localparam logic [127:0] LX   = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
    localparam logic [127:0] L9   = 128'h99990000_99991111_99992222_99993333;
    localparam logic [127:0] L20A = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    localparam logic [127:0] L20B = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    localparam logic [127:0] L20C = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    localparam logic [127:0] L1A  = 128'h0123456789ABCDEF_FEDCBA9876543210;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit u, input bit rd, input bit wr, input logic [27:0] addr,
                         input logic [127:0] wd);
        if (!u) begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
        end else begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
        end
    endtask

    // Cycles until mem_ready is seen, or -1 once the budget runs out.
    task automatic wait_ready(input bit u, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < 40) begin
            @(negedge clk);
            i++;
            if ((u ? b_ready : a_ready) === 1'b1) n = i;
        end
    endtask

    // Full transaction; returns at the negedge of the response cycle with requests dropped.
    task automatic txn(input bit u, input bit rd, input bit wr, input logic [27:0] addr,
                       input logic [127:0] wd, output int lat);
        drive(u, rd, wr, addr, wd);
        wait_ready(u, lat);
        drive(u, 1'b0, 1'b0, addr, '0);
    endtask

    initial begin
        int lat;
        int pulses;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        tick(2);
        chk("reset_ready", 128'(a_ready), 128'd0);
        chk("reset_rdata", a_rdata, 128'd0);
        chk("reset_perr", 128'(a_perr), 128'd0);
        chk("reset_rdc", 128'(a_rdc), 128'd0);
        chk("reset_wrc", 128'(a_wrc), 128'd0);
        rst_n = 1'b1;
        tick(1);

        // Preload line 5, then reset: storage must survive, counters must not.
        txn(1'b0, 1'b0, 1'b1, 28'h5, L5, lat);
        chk("preload_lat", 128'(lat), 128'd4);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("rst_clears_wrc", 128'(a_wrc), 128'd0);

        // Read of preloaded line, exact latency and single-cycle pulse.
        txn(1'b0, 1'b1, 1'b0, 28'h5, '0, lat);
        chk("rd5_lat", 128'(lat), 128'd4);
        chk("rd5_data", a_rdata, L5);
        tick(1);
        chk("rd5_pulse_one", 128'(a_ready), 128'd0);
        chk("rd5_rdc", 128'(a_rdc), 128'd1);
        txn(1'b0, 1'b1, 1'b0, 28'h405, '0, lat);
        chk("alias_data", a_rdata, L5);
        tick(1);

        // Write then read back.
        txn(1'b0, 1'b0, 1'b1, 28'h12, L12, lat);
        chk("wr12_lat", 128'(lat), 128'd4);
        tick(1);
        txn(1'b0, 1'b1, 1'b0, 28'h12, '0, lat);
        chk("rd12_data", a_rdata, L12);
        tick(1);
        chk("t2_wrc", 128'(a_wrc), 128'd1);
        chk("t2_rdc", 128'(a_rdc), 128'd3);

        // Write-back then allocate, back to back.
        txn(1'b0, 1'b0, 1'b1, 28'h7, L7, lat);
        tick(1);
        txn(1'b0, 1'b0, 1'b1, 28'h3, L3, lat);
        chk("wb_lat", 128'(lat), 128'd4);
        chk("wb_rdata_kept", a_rdata, L12);
        txn(1'b0, 1'b1, 1'b0, 28'h7, '0, lat);
        chk("alloc_lat", 128'(lat), 128'd5);
        chk("alloc_data", a_rdata, L7);
        tick(1);
        txn(1'b0, 1'b1, 1'b0, 28'h3, '0, lat);
        chk("rd3_data", a_rdata, L3);
        tick(1);
        chk("t3_rdc", 128'(a_rdc), 128'd5);
        chk("t3_wrc", 128'(a_wrc), 128'd3);

        // Aborted read, then an aborted write.
        drive(1'b0, 1'b1, 1'b0, 28'h12, '0);
        tick(2);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_ready === 1'b1) pulses++;
        end
        chk("abort_rd_pulses", 128'(pulses), 128'd0);
        chk("abort_rd_rdc", 128'(a_rdc), 128'd5);
        txn(1'b0, 1'b1, 1'b0, 28'h12, '0, lat);
        chk("after_abort_lat", 128'(lat), 128'd4);
        tick(1);
        drive(1'b0, 1'b0, 1'b1, 28'h12, LX);
        tick(2);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_ready === 1'b1) pulses++;
        end
        chk("abort_wr_pulses", 128'(pulses), 128'd0);
        txn(1'b0, 1'b1, 1'b0, 28'h12, '0, lat);
        chk("abort_wr_data", a_rdata, L12);
        tick(1);
        chk("t4_wrc", 128'(a_wrc), 128'd3);
        chk("t4_rdc", 128'(a_rdc), 128'd7);

        // Simultaneous read and write.
        txn(1'b0, 1'b1, 1'b1, 28'h9, L9, lat);
        chk("both_lat", 128'(lat), 128'd4);
        chk("both_perr", 128'(a_perr), 128'd1);
        tick(1);
        chk("both_wrc", 128'(a_wrc), 128'd4);
        chk("both_rdc", 128'(a_rdc), 128'd7);
        txn(1'b0, 1'b1, 1'b0, 28'h9, '0, lat);
        chk("rd9_data", a_rdata, L9);
        tick(1);
        chk("perr_sticky", 128'(a_perr), 128'd1);

        // Reset during RESP and during BUSY of writes to 0x20.
        txn(1'b0, 1'b0, 1'b1, 28'h20, L20A, lat);
        tick(1);
        drive(1'b0, 1'b0, 1'b1, 28'h20, L20B);
        wait_ready(1'b0, lat);
        chk("rst_resp_seen", 128'(lat), 128'd4);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_ready", 128'(a_ready), 128'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("rst_perr", 128'(a_perr), 128'd0);
        chk("rst_rdata", a_rdata, 128'd0);
        drive(1'b0, 1'b0, 1'b1, 28'h20, L20C);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_ready", 128'(a_ready), 128'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        txn(1'b0, 1'b1, 1'b0, 28'h20, '0, lat);
        chk("rd20_old", a_rdata, L20A);
        tick(1);
        chk("t6_rdc", 128'(a_rdc), 128'd1);
        chk("t6_wrc", 128'(a_wrc), 128'd0);

        // LATENCY=1 instance with 2-bit counters.
        txn(1'b1, 1'b0, 1'b1, 28'h1, L1A, lat);
        chk("l1_wr_lat", 128'(lat), 128'd1);
        tick(1);
        txn(1'b1, 1'b1, 1'b0, 28'h1, '0, lat);
        chk("l1_rd_lat", 128'(lat), 128'd1);
        chk("l1_rd_data", b_rdata, L1A);
        tick(1);
        repeat (3) begin
            txn(1'b1, 1'b1, 1'b0, 28'h1, '0, lat);
            tick(1);
        end
        chk("l1_rdc_sat", 128'(b_rdc), 128'd3);
        chk("l1_wrc", 128'(b_wrc), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
